// File: rtl/btb_assoc_if.sv
// Fetch/execute-side bundle for the set-associative branch target buffer.
// The master drives lookups, resolved-branch updates and flush requests; the BTB is the slave.
interface btb_assoc_if #(
  parameter int unsigned WORD_W = 32
);
  logic [WORD_W-1:0] pc_fetch;
  logic              hit;
  logic              pred_outcome;
  logic [WORD_W-1:0] pred_target;
  logic              update_btb;
  logic [WORD_W-1:0] pc;
  logic              branch_outcome;
  logic [WORD_W-1:0] branch_target;
  logic              flush;
  logic              busy;

  modport master (
    output pc_fetch,
    output update_btb,
    output pc,
    output branch_outcome,
    output branch_target,
    output flush,
    input  hit,
    input  pred_outcome,
    input  pred_target,
    input  busy
  );

  modport slave (
    input  pc_fetch,
    input  update_btb,
    input  pc,
    input  branch_outcome,
    input  branch_target,
    input  flush,
    output hit,
    output pred_outcome,
    output pred_target,
    output busy
  );
endinterface

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer: combinational lookup, one registered update per cycle
// with 2-bit-style saturating direction counters, least-recently-updated replacement, flush walk.
module btb_assoc #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned NSETS  = 16,
  parameter int unsigned NWAYS  = 2,
  parameter int unsigned CNT_W  = 2
) (
  input logic        CLK,
  input logic        nRST,
  btb_assoc_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(NSETS);
  localparam int unsigned AGE_W = (NWAYS > 1) ? $clog2(NWAYS) : 1;
  localparam int unsigned TAG_W = WORD_W - 2 - IDX_W;

  localparam logic [CNT_W-1:0] CntMax  = '1;
  localparam logic [CNT_W-1:0] CntWeak = CNT_W'(1) << (CNT_W - 1);

  typedef enum logic [0:0] {StIdle, StFlush} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  logic             valid_q  [NSETS][NWAYS];
  logic [TAG_W-1:0] tag_q    [NSETS][NWAYS];
  logic [WORD_W-1:0] target_q [NSETS][NWAYS];
  logic [CNT_W-1:0] cnt_q    [NSETS][NWAYS];
  logic [AGE_W-1:0] age_q    [NSETS][NWAYS];

  // ---------------------------------------------------------------------------------------------
  // Lookup
  // ---------------------------------------------------------------------------------------------
  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_match;
  logic [AGE_W-1:0] f_way;

  assign f_idx = bus.pc_fetch[2 +: IDX_W];
  assign f_tag = bus.pc_fetch[WORD_W-1 -: TAG_W];

  // Lowest matching way wins if duplicates ever exist.
  always_comb begin
    f_match = 1'b0;
    f_way   = '0;
    for (int unsigned w = 0; w < NWAYS; w++) begin
      if (!f_match && valid_q[f_idx][w] && (tag_q[f_idx][w] == f_tag)) begin
        f_match = 1'b1;
        f_way   = AGE_W'(w);
      end
    end
  end

  logic busy;
  assign busy = (state_q == StFlush);

  always_comb begin
    bus.hit          = f_match && !busy;
    bus.pred_outcome = 1'b0;
    bus.pred_target  = '0;
    if (bus.hit) begin
      bus.pred_outcome = cnt_q[f_idx][f_way][CNT_W-1];
      bus.pred_target  = target_q[f_idx][f_way];
    end
  end

  assign bus.busy = busy;

  // ---------------------------------------------------------------------------------------------
  // Update way selection
  // ---------------------------------------------------------------------------------------------
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_match;
  logic [AGE_W-1:0] u_way;
  logic             inv_found;
  logic [AGE_W-1:0] inv_way;
  logic [AGE_W-1:0] lru_way;
  logic [AGE_W-1:0] lru_age;
  logic [AGE_W-1:0] tgt_way;
  logic [AGE_W-1:0] tgt_age;
  logic             upd_go;
  logic             do_write;

  assign u_idx = bus.pc[2 +: IDX_W];
  assign u_tag = bus.pc[WORD_W-1 -: TAG_W];

  always_comb begin
    u_match   = 1'b0;
    u_way     = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    lru_way   = '0;
    lru_age   = age_q[u_idx][0];
    for (int unsigned w = 0; w < NWAYS; w++) begin
      if (!u_match && valid_q[u_idx][w] && (tag_q[u_idx][w] == u_tag)) begin
        u_match = 1'b1;
        u_way   = AGE_W'(w);
      end
      if (!inv_found && !valid_q[u_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = AGE_W'(w);
      end
      if (age_q[u_idx][w] > lru_age) begin
        lru_age = age_q[u_idx][w];
        lru_way = AGE_W'(w);
      end
    end
  end

  assign tgt_way  = u_match ? u_way : (inv_found ? inv_way : lru_way);
  assign tgt_age  = age_q[u_idx][tgt_way];
  assign upd_go   = bus.update_btb && (state_q == StIdle) && !bus.flush;
  assign do_write = upd_go && (u_match || bus.branch_outcome);

  // ---------------------------------------------------------------------------------------------
  // Flush sequencer
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (bus.flush) begin
          state_d = StFlush;
          ptr_d   = '0;
        end
      end
      StFlush: begin
        if (ptr_q == IDX_W'(NSETS - 1)) begin
          state_d = StIdle;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= StIdle;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Table storage
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned s = 0; s < NSETS; s++) begin
        for (int unsigned w = 0; w < NWAYS; w++) begin
          valid_q[s][w]  <= 1'b0;
          tag_q[s][w]    <= '0;
          target_q[s][w] <= '0;
          cnt_q[s][w]    <= '0;
          age_q[s][w]    <= AGE_W'(w);
        end
      end
    end else if (state_q == StFlush) begin
      for (int unsigned w = 0; w < NWAYS; w++) begin
        valid_q[ptr_q][w] <= 1'b0;
      end
    end else if (do_write) begin
      valid_q[u_idx][tgt_way] <= 1'b1;
      tag_q[u_idx][tgt_way]   <= u_tag;
      if (u_match) begin
        if (bus.branch_outcome) begin
          target_q[u_idx][tgt_way] <= bus.branch_target;
          if (cnt_q[u_idx][tgt_way] != CntMax) begin
            cnt_q[u_idx][tgt_way] <= cnt_q[u_idx][tgt_way] + CNT_W'(1);
          end
        end else if (cnt_q[u_idx][tgt_way] != '0) begin
          cnt_q[u_idx][tgt_way] <= cnt_q[u_idx][tgt_way] - CNT_W'(1);
        end
      end else begin
        target_q[u_idx][tgt_way] <= bus.branch_target;
        cnt_q[u_idx][tgt_way]    <= CntWeak;
      end
      // Touched way becomes MRU; only ways younger than it age, keeping a permutation.
      for (int unsigned w = 0; w < NWAYS; w++) begin
        if (AGE_W'(w) == tgt_way) begin
          age_q[u_idx][w] <= '0;
        end else if (age_q[u_idx][w] < tgt_age) begin
          age_q[u_idx][w] <= age_q[u_idx][w] + AGE_W'(1);
        end
      end
    end
  end

  // Word-alignment bits never take part in indexing.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{bus.pc_fetch[1:0], bus.pc[1:0]};

endmodule

// File: tb/tb_btb_assoc.sv
// Directed bench for btb_assoc: timestamp-based LRU reference model checked every cycle,
// plus literal expectations along the directed sequence.
module tb_btb_assoc;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned NSETS  = 16;
  localparam int unsigned NWAYS  = 2;
  localparam int unsigned CNT_W  = 2;
  localparam int          CMAX   = (1 << CNT_W) - 1;
  localparam int          CWEAK  = 1 << (CNT_W - 1);

  logic CLK  = 1'b0;
  logic nRST = 1'b0;

  btb_assoc_if #(.WORD_W(WORD_W)) bus ();

  btb_assoc #(
    .WORD_W(WORD_W),
    .NSETS (NSETS),
    .NWAYS (NWAYS),
    .CNT_W (CNT_W)
  ) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: entries per set, replacement by oldest update timestamp.
  bit          m_v     [NSETS][NWAYS];
  logic [31:0] m_tag   [NSETS][NWAYS];
  logic [31:0] m_tgt   [NSETS][NWAYS];
  int          m_cnt   [NSETS][NWAYS];
  longint      m_stamp [NSETS][NWAYS];
  longint      m_time;
  int          m_flush_left;

  function automatic int set_of(input logic [31:0] p);
    return int'((p >> 2) % NSETS);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] p);
    return p >> (2 + $clog2(NSETS));
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NSETS; s++) begin
      for (int w = 0; w < NWAYS; w++) begin
        m_v[s][w]     = 0;
        m_tag[s][w]   = '0;
        m_tgt[s][w]   = '0;
        m_cnt[s][w]   = 0;
        m_stamp[s][w] = -w;  // way NWAYS-1 starts as the least recently updated
      end
    end
    m_time       = 0;
    m_flush_left = 0;
  endtask

  task automatic model_lookup(input logic [31:0] p, output logic h, output logic o,
                              output logic [31:0] t);
    int s;
    s = set_of(p);
    h = 0;
    o = 0;
    t = '0;
    if (m_flush_left == 0) begin
      for (int w = 0; w < NWAYS; w++) begin
        if (!h && m_v[s][w] && m_tag[s][w] == tag_of(p)) begin
          h = 1;
          o = (m_cnt[s][w] >= CWEAK);
          t = m_tgt[s][w];
        end
      end
    end
  endtask

  task automatic model_update(input logic [31:0] p, input logic tk, input logic [31:0] tg);
    int  s;
    int  way;
    bit  found;
    s     = set_of(p);
    found = 0;
    way   = 0;
    for (int w = 0; w < NWAYS; w++) begin
      if (!found && m_v[s][w] && m_tag[s][w] == tag_of(p)) begin
        found = 1;
        way   = w;
      end
    end
    if (found) begin
      if (tk) begin
        m_tgt[s][way] = tg;
        if (m_cnt[s][way] < CMAX) m_cnt[s][way]++;
      end else if (m_cnt[s][way] > 0) begin
        m_cnt[s][way]--;
      end
      m_time++;
      m_stamp[s][way] = m_time;
    end else if (tk) begin
      way = -1;
      for (int w = 0; w < NWAYS; w++) if (way < 0 && !m_v[s][w]) way = w;
      if (way < 0) begin
        way = 0;
        for (int w = 1; w < NWAYS; w++) if (m_stamp[s][w] < m_stamp[s][way]) way = w;
      end
      m_v[s][way]   = 1;
      m_tag[s][way] = tag_of(p);
      m_tgt[s][way] = tg;
      m_cnt[s][way] = CWEAK;
      m_time++;
      m_stamp[s][way] = m_time;
    end
  endtask

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      model_reset();
    end else if (m_flush_left > 0) begin
      for (int w = 0; w < NWAYS; w++) m_v[NSETS - m_flush_left][w] = 0;
      m_flush_left--;
    end else if (bus.flush) begin
      m_flush_left = NSETS;
    end else if (bus.update_btb) begin
      model_update(bus.pc, bus.branch_outcome, bus.branch_target);
    end
  end

  logic        e_hit;
  logic        e_out;
  logic [31:0] e_tgt;

  always @(negedge CLK) begin
    if (nRST) begin
      model_lookup(bus.pc_fetch, e_hit, e_out, e_tgt);
      chk("cyc.hit", 32'(bus.hit), 32'(e_hit));
      chk("cyc.pred_outcome", 32'(bus.pred_outcome), 32'(e_out));
      chk("cyc.pred_target", bus.pred_target, e_tgt);
      chk("cyc.busy", 32'(bus.busy), 32'(m_flush_left > 0));
    end
  end

  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic upd(input logic [31:0] p, input logic tk, input logic [31:0] tg);
    bus.update_btb     = 1'b1;
    bus.pc             = p;
    bus.branch_outcome = tk;
    bus.branch_target  = tg;
    cycle();
    bus.update_btb = 1'b0;
  endtask

  task automatic look(input string nm, input logic [31:0] p, input logic eh, input logic eo,
                      input logic [31:0] et);
    bus.pc_fetch = p;
    #1;
    chk({nm, ".hit"}, 32'(bus.hit), 32'(eh));
    chk({nm, ".pred_outcome"}, 32'(bus.pred_outcome), 32'(eo));
    chk({nm, ".pred_target"}, bus.pred_target, et);
  endtask

  int n_busy;

  initial begin
    bus.pc_fetch       = '0;
    bus.update_btb     = 1'b0;
    bus.pc             = '0;
    bus.branch_outcome = 1'b0;
    bus.branch_target  = '0;
    bus.flush          = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;

    // Cold miss
    look("cold", 32'h100, 0, 0, 32'h0);
    chk("cold.busy", 32'(bus.busy), 32'd0);
    cycle();

    // Allocate; same-cycle lookup sees pre-update contents
    bus.pc_fetch = 32'h100;
    look("same_cycle", 32'h100, 0, 0, 32'h0);
    upd(32'h100, 1, 32'h200);
    look("alloc", 32'h100, 1, 1, 32'h200);

    // Counter hysteresis
    upd(32'h100, 0, 32'h0);
    look("nt1", 32'h100, 1, 0, 32'h200);
    upd(32'h100, 0, 32'h0);
    look("nt2", 32'h100, 1, 0, 32'h200);
    upd(32'h100, 0, 32'h0);
    upd(32'h100, 1, 32'h200);
    look("nt3_sat", 32'h100, 1, 0, 32'h200);
    upd(32'h100, 1, 32'h200);
    look("t2", 32'h100, 1, 1, 32'h200);
    upd(32'h100, 1, 32'h200);
    upd(32'h100, 1, 32'h200);
    upd(32'h100, 0, 32'h0);
    look("t_sat", 32'h100, 1, 1, 32'h200);
    upd(32'h100, 1, 32'h300);
    look("new_tgt", 32'h100, 1, 1, 32'h300);

    // Not-taken miss does not allocate
    upd(32'h500, 0, 32'h999);
    look("no_alloc", 32'h500, 0, 0, 32'h0);

    // LRU within set 0
    upd(32'h140, 1, 32'h1400);
    look("lru.140", 32'h140, 1, 1, 32'h1400);
    upd(32'h100, 1, 32'h300);
    upd(32'h180, 1, 32'h1800);
    look("lru.140_gone", 32'h140, 0, 0, 32'h0);
    look("lru.100", 32'h100, 1, 1, 32'h300);
    look("lru.180", 32'h180, 1, 1, 32'h1800);
    upd(32'h1C0, 1, 32'h1C00);
    look("lru.100_gone", 32'h100, 0, 0, 32'h0);
    look("lru.1c0", 32'h1C0, 1, 1, 32'h1C00);
    look("lru.180b", 32'h180, 1, 1, 32'h1800);
    cycle();

    // Flush: exact length, updates and re-flush ignored while busy
    upd(32'h204, 1, 32'h2040);
    upd(32'h208, 1, 32'h2080);
    bus.pc_fetch = 32'h180;
    bus.flush    = 1'b1;
    cycle();
    bus.flush = 1'b0;
    n_busy    = 0;
    while (bus.busy && n_busy < 64) begin
      n_busy++;
      if (n_busy == 3) begin
        bus.update_btb     = 1'b1;
        bus.pc             = 32'h30C;
        bus.branch_outcome = 1'b1;
        bus.branch_target  = 32'h3030;
      end
      if (n_busy == 4) bus.update_btb = 1'b0;
      if (n_busy == 6) bus.flush = 1'b1;
      if (n_busy == 7) bus.flush = 1'b0;
      cycle();
    end
    bus.update_btb = 1'b0;
    bus.flush      = 1'b0;
    chk("flush.len", 32'(n_busy), 32'd16);
    look("flush.180", 32'h180, 0, 0, 32'h0);
    look("flush.204", 32'h204, 0, 0, 32'h0);
    look("flush.208", 32'h208, 0, 0, 32'h0);
    cycle();
    look("flush.30c_lost", 32'h30C, 0, 0, 32'h0);
    look("flush.1c0", 32'h1C0, 0, 0, 32'h0);

    // flush and update in the same idle cycle: flush wins
    bus.flush          = 1'b1;
    bus.update_btb     = 1'b1;
    bus.pc             = 32'h100;
    bus.branch_outcome = 1'b1;
    bus.branch_target  = 32'h111;
    cycle();
    bus.flush      = 1'b0;
    bus.update_btb = 1'b0;
    chk("flush_upd.busy", 32'(bus.busy), 32'd1);
    n_busy = 0;
    while (bus.busy && n_busy < 64) begin
      n_busy++;
      cycle();
    end
    chk("flush_upd.len", 32'(n_busy), 32'd16);
    look("flush_upd.100", 32'h100, 0, 0, 32'h0);

    // Reset during flush
    upd(32'h100, 1, 32'h200);
    look("pre_rst", 32'h100, 1, 1, 32'h200);
    bus.flush = 1'b1;
    cycle();
    bus.flush = 1'b0;
    repeat (5) cycle();
    chk("midflush.busy_before", 32'(bus.busy), 32'd1);
    nRST = 1'b0;
    #1;
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.hit", 32'(bus.hit), 32'd0);
    chk("rst.target", bus.pred_target, 32'h0);
    cycle();
    nRST = 1'b1;
    look("post_rst", 32'h100, 0, 0, 32'h0);
    upd(32'h100, 1, 32'h444);
    look("post_rst.alloc", 32'h100, 1, 1, 32'h444);
    upd(32'h100, 0, 32'h0);
    look("post_rst.weak", 32'h100, 1, 0, 32'h444);
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
